gba_cart_ctrl: RTL and testbench
================================

# gba_cart_ctrl

Cartridge bus sequencer between `mem_top`'s game-pak chip-select path and the external cart interface (`CART_ADDR`/`CART_RD`/`CART_WR`/`CART_DI`/`CART_DO`). It converts single-cycle CPU/DMA bus requests into timed 16-bit ROM cycles or 8-bit SRAM cycles. Timing follows the WAITCNT wait-state fields, with sequential/non-sequential selection. The block holds the shared bus pause until data is valid, and it splits 32-bit accesses into two halfword cycles.

## Interface

Parameters:
- none

Ports (name, direction, width, meaning):
- `clk` in 1: GBA system clock (16.78 MHz domain).
- `rst_b` in 1: asynchronous active-low reset.
- `req` in 1: cart chip-select from `mem_top` (address in 0x08000000–0x0FFFFFFF).
- `write` in 1: 1 = write, 0 = read.
- `addr` in 32: byte address.
- `size` in 2: 0 = byte, 1 = halfword, 2 = word.
- `wdata` in 32: write data.
- `waitcnt` in 16: WAITCNT register value (`IO_reg_datas[WAITCNT]`).
- `pause` out 1: stall to CPU/DMA; ORed into `bus_pause`.
- `rdata` out 32: read data, valid in the DONE cycle and held until the next capture.
- `cart_addr` out 32: address to cart.
- `cart_rd` out 1: read strobe.
- `cart_wr` out 1: write strobe.
- `cart_do` out 16: write data to cart.
- `cart_di` in 16: read data from cart.

## Operation

Regions and wait-state counts, decoded from `addr[27:25]`:
- 0x08/0x09 = WS0. First access N from `waitcnt[3:2]` = {4,3,2,8}. Sequential access S from `waitcnt[4]` = {2,1}.
- 0x0A/0x0B = WS1. N from `[6:5]` = {4,3,2,8}. S from `[7]` = {4,1}.
- 0x0C/0x0D = WS2. N from `[9:8]` = {4,3,2,8}. S from `[10]` = {8,1}.
- 0x0E/0x0F = SRAM. Wait count from `[1:0]` = {4,3,2,8}. SRAM accesses are never sequential.

Sequential detection:
- A ROM access is sequential when `seq_valid` is set, `addr[24:1]` equals `seq_addr`, and `addr[16:1] != 0` (a 128 KB boundary forces non-sequential).
- At the end of each ROM halfword cycle: `seq_addr` ← that halfword's address + 1 and `seq_valid` ← 1.
- `seq_valid` is cleared on any IDLE cycle with `req` = 0, on any SRAM access, and on reset.

FSM states: IDLE, ACC1, ACC2, DONE.
- IDLE with `req` = 1:
  - Latch `addr`, `size`, `write`, `wdata`.
  - Load the counter with N, or with S if the access is sequential.
  - Go to ACC1. `pause` = 1 combinationally in this cycle.
- ACC1 (first/only halfword):
  - Drive `cart_addr` = {`addr[31:1]`, 0} (SRAM: full `addr`).
  - Assert `cart_rd` or `cart_wr` throughout the state.
  - Decrement the counter each cycle. At counter = 0, capture `cart_di` into the low data register.
  - Then go to ACC2 if `size` = word in a ROM region (counter ← S); otherwise go to DONE.
- ACC2 (upper halfword): `cart_addr` = latched address + 2. Same rules as ACC1, capturing into the high data register, then go to DONE.
- DONE: `pause` = 0, `rdata` updated, next state IDLE.
  - A `req` still high in DONE is not re-accepted.
  - A new access is accepted only in the following IDLE cycle.

Read data formatting:
- ROM word: {hi, lo}.
- ROM halfword: {lo, lo}.
- ROM byte: byte `addr[0]` of lo, replicated ×4.
- SRAM (any size): `cart_di[7:0]` replicated ×4.

Write data:
- ROM halfword: `cart_do` = `wdata[15:0]`.
- ROM word: `wdata[15:0]` in ACC1, then `wdata[31:16]` in ACC2.
- ROM byte: {2{`wdata[7:0]`}}.
- SRAM: {8'h00, byte}, where the byte is `wdata[7:0]`. Word/halfword SRAM writes use `wdata[7:0]`.

`waitcnt` is sampled only at acceptance. Changes mid-access do not affect the access in flight.

## Timing

- Reset values (async, immediate): state IDLE; `pause`, `cart_rd`, `cart_wr` = 0; `cart_addr`, `cart_do`, `rdata` = 0; `seq_valid` = 0; counter = 0.
- Halfword/byte/SRAM access with wait count W:
  - `pause` high for W+2 cycles (accept cycle + W+1 ACC1 cycles).
  - Strobe high for W+1 cycles.
  - DONE follows immediately after.
- ROM word access:
  - `pause` high for N+S+3 cycles (or 2S+3 if the first halfword is sequential).
  - The strobe stays high continuously across ACC1→ACC2; only `cart_addr` steps by 2.
- `cart_di` is sampled on the last strobe cycle of each halfword.
- `rst_b` asserted mid-access aborts immediately: strobes drop in the same instant, and no DONE occurs.

## Test plan

- Non-sequential halfword read: `waitcnt` = 0x0000, read halfword at 0x08000000, `cart_di` = 0x1234 → `cart_rd` high 5 cycles, `pause` high 6 cycles, `rdata` = 0x12341234 in DONE.
- ROM word read: `waitcnt` = 0x0014, word read at 0x08000100, `cart_di` = 0xBBBB at 0x100 and 0xAAAA at 0x102 → ACC1 4 cycles, ACC2 2 cycles, `rdata` = 0xAAAABBBB, `cart_rd` unbroken for 6 cycles.
- Back-to-back sequential access: word read 0x08000100 followed in the next IDLE cycle by halfword 0x08000104 → the second access uses S (2 cycles with `waitcnt` = 0x0014). With one idle gap in between, it uses N (4 cycles).
- Boundary and SRAM:
  - Halfword read at 0x0801FFFE, then 0x08020000 back-to-back → the second access is non-sequential (N).
  - SRAM byte write 0x0E000005 with `wdata` = 0x000000A5 and `waitcnt[1:0]` = 3 → `cart_wr` high 9 cycles, `cart_do` = 0x00A5.
- Async reset mid-ACC2 of a word read: `rst_b` low → `cart_rd`, `pause`, `rdata` = 0 immediately, state IDLE. After release, a new halfword read is non-sequential.

Source files
------------

// File: rtl/gba_cart_ctrl.sv
// Game-pak bus sequencer: turns one-cycle CPU/DMA requests into
// WAITCNT-timed ROM halfword cycles or SRAM byte cycles on the cart pins.
module gba_cart_ctrl (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [15:0] waitcnt,
  output logic        pause,
  output logic [31:0] rdata,
  output logic [31:0] cart_addr,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic [15:0] cart_do,
  input  logic [15:0] cart_di
);

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] a_q;
  logic [1:0]  sz_q;
  logic        wr_q;
  logic [31:0] wd_q;
  logic        sram_q;
  logic        two_q;
  logic [3:0]  cnt_q;
  logic [3:0]  s_q;
  logic [15:0] lo_q;
  logic [23:0] seq_addr;
  logic        seq_valid;

  logic        is_sram;
  logic        seq_hit;
  logic [3:0]  n_w;
  logic [3:0]  s_w;
  logic [15:0] do_lo;
  logic [31:0] fmt_lo;
  logic        unused_wc;

  assign unused_wc = ^waitcnt[15:11];

  function automatic logic [3:0] n_dec(input logic [1:0] f);
    case (f)
      2'd0:    n_dec = 4'd4;
      2'd1:    n_dec = 4'd3;
      2'd2:    n_dec = 4'd2;
      default: n_dec = 4'd8;
    endcase
  endfunction

  always_comb begin
    is_sram = (addr[26:25] == 2'b11);
    case (addr[26:25])
      2'b00: begin
        n_w = n_dec(waitcnt[3:2]);
        s_w = waitcnt[4] ? 4'd1 : 4'd2;
      end
      2'b01: begin
        n_w = n_dec(waitcnt[6:5]);
        s_w = waitcnt[7] ? 4'd1 : 4'd4;
      end
      2'b10: begin
        n_w = n_dec(waitcnt[9:8]);
        s_w = waitcnt[10] ? 4'd1 : 4'd8;
      end
      default: begin
        n_w = n_dec(waitcnt[1:0]);
        s_w = n_w;
      end
    endcase
    // a 128 KB page crossing always restarts with a full N cycle
    seq_hit = seq_valid && !is_sram
           && (addr[24:1] == seq_addr)
           && (addr[16:1] != 16'd0);
  end

  always_comb begin
    do_lo = 16'h0000;
    if (wr_q) begin
      if (sram_q)
        do_lo = {8'h00, wd_q[7:0]};
      else if (sz_q == 2'd0)
        do_lo = {2{wd_q[7:0]}};
      else
        do_lo = wd_q[15:0];
    end
    if (sram_q)
      fmt_lo = {4{cart_di[7:0]}};
    else if (sz_q == 2'd0)
      fmt_lo = {4{a_q[0] ? cart_di[15:8] : cart_di[7:0]}};
    else
      fmt_lo = {2{cart_di}};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pause     = 1'b0;
    cart_rd   = 1'b0;
    cart_wr   = 1'b0;
    cart_addr = 32'h0;
    cart_do   = 16'h0;
    unique case (state_q)
      IDLE: begin
        pause = req;
        if (req) state_d = ACC1;
      end
      ACC1: begin
        pause     = 1'b1;
        cart_rd   = !wr_q;
        cart_wr   = wr_q;
        cart_addr = sram_q ? a_q : {a_q[31:1], 1'b0};
        cart_do   = do_lo;
        if (cnt_q == 4'd0) state_d = two_q ? ACC2 : DONE;
      end
      ACC2: begin
        pause     = 1'b1;
        cart_rd   = !wr_q;
        cart_wr   = wr_q;
        cart_addr = {a_q[31:1], 1'b0} + 32'd2;
        cart_do   = wr_q ? wd_q[31:16] : 16'h0;
        if (cnt_q == 4'd0) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q       <= '0;
      sz_q      <= '0;
      wr_q      <= 1'b0;
      wd_q      <= '0;
      sram_q    <= 1'b0;
      two_q     <= 1'b0;
      cnt_q     <= '0;
      s_q       <= '0;
      lo_q      <= '0;
      seq_addr  <= '0;
      seq_valid <= 1'b0;
      rdata     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            a_q    <= addr;
            sz_q   <= size;
            wr_q   <= write;
            wd_q   <= wdata;
            sram_q <= is_sram;
            two_q  <= (size == 2'd2) && !is_sram;
            cnt_q  <= seq_hit ? s_w : n_w;
            s_q    <= s_w;
            if (is_sram) seq_valid <= 1'b0;
          end else begin
            seq_valid <= 1'b0;
          end
        end
        ACC1: begin
          if (cnt_q == 4'd0) begin
            lo_q <= cart_di;
            if (!sram_q) begin
              seq_addr  <= a_q[24:1] + 24'd1;
              seq_valid <= 1'b1;
            end
            if (two_q)     cnt_q <= s_q;
            else if (!wr_q) rdata <= fmt_lo;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACC2: begin
          if (cnt_q == 4'd0) begin
            seq_addr  <= a_q[24:1] + 24'd2;
            seq_valid <= 1'b1;
            if (!wr_q) rdata <= {cart_di, lo_q};
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_cart_ctrl.sv
// Bench for gba_cart_ctrl: transaction-level cart model predicts every
// output cycle; directed cases pin the model with literal timings.
module tb_gba_cart_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = '0;
  logic [31:0] wdata = '0;
  logic [15:0] waitcnt = '0;
  logic        pause;
  logic [31:0] rdata;
  logic [31:0] cart_addr;
  logic        cart_rd;
  logic        cart_wr;
  logic [15:0] cart_do;
  logic [15:0] cart_di = '0;

  gba_cart_ctrl dut (
    .clk(clk), .rst_b(rst_b), .req(req), .write(write),
    .addr(addr), .size(size), .wdata(wdata), .waitcnt(waitcnt),
    .pause(pause), .rdata(rdata), .cart_addr(cart_addr),
    .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_do(cart_do),
    .cart_di(cart_di)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        chk_en = 1'b0;
  logic        exp_pause, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_rdata;
  logic [15:0] exp_do;

  logic        m_sv = 1'b0;
  logic [23:0] m_sa = '0;
  logic [31:0] m_rdata = '0;
  int          n_pause, n_strobe;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      chk("pause", {31'b0, pause}, {31'b0, exp_pause});
      chk("cart_rd", {31'b0, cart_rd}, {31'b0, exp_rd});
      chk("cart_wr", {31'b0, cart_wr}, {31'b0, exp_wr});
      chk("cart_addr", cart_addr, exp_addr);
      chk("cart_do", {16'b0, cart_do}, {16'b0, exp_do});
      chk("rdata", rdata, exp_rdata);
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [1:0] sz, input logic [31:0] wd,
                     input logic [15:0] wc, input logic [15:0] di,
                     input logic ep, input logic er, input logic ew,
                     input logic [31:0] ea, input logic [15:0] edo);
    @(negedge clk);
    req = r; write = w; addr = a; size = sz;
    wdata = wd; waitcnt = wc; cart_di = di;
    exp_pause = ep; exp_rd = er; exp_wr = ew;
    exp_addr = ea; exp_do = edo; exp_rdata = m_rdata;
    chk_en = 1'b1;
    #1;
    if (pause) n_pause++;
    if (cart_rd || cart_wr) n_strobe++;
  endtask

  task automatic junk(input logic r, input logic [15:0] di,
                      input logic ep, input logic er, input logic ew,
                      input logic [31:0] ea, input logic [15:0] edo);
    cyc(r, 1'($urandom), $urandom, 2'($urandom), $urandom,
        16'($urandom), di, ep, er, ew, ea, edo);
  endtask

  function automatic int ntbl(input logic [1:0] f);
    case (f)
      2'd0:    return 4;
      2'd1:    return 3;
      2'd2:    return 2;
      default: return 8;
    endcase
  endfunction

  task automatic access(input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd,
                        input logic [15:0] wc, input logic [15:0] lo,
                        input logic [15:0] hi, input int gap,
                        input logic rq_done, input logic abort);
    logic sram, two, sq;
    int nn, ss, w1;
    logic [31:0] a1, a2;
    logic [15:0] d1, d2;
    sram = (a[26:25] == 2'd3);
    case (a[26:25])
      2'd0:    begin nn = ntbl(wc[3:2]); ss = wc[4]  ? 1 : 2; end
      2'd1:    begin nn = ntbl(wc[6:5]); ss = wc[7]  ? 1 : 4; end
      2'd2:    begin nn = ntbl(wc[9:8]); ss = wc[10] ? 1 : 8; end
      default: begin nn = ntbl(wc[1:0]); ss = 0; end
    endcase
    sq = !sram && m_sv && (a[24:1] == m_sa) && (a[16:1] != 16'd0);
    w1 = sq ? ss : nn;
    two = (sz == 2'd2) && !sram;
    a1 = sram ? a : {a[31:1], 1'b0};
    a2 = {a[31:1], 1'b0} + 32'd2;
    if (!w)               d1 = 16'h0;
    else if (sram)        d1 = {8'h00, wd[7:0]};
    else if (sz == 2'd0)  d1 = {2{wd[7:0]}};
    else                  d1 = wd[15:0];
    d2 = w ? wd[31:16] : 16'h0;
    n_pause = 0;
    n_strobe = 0;
    cyc(1'b1, w, a, sz, wd, wc, 16'($urandom), 1'b1, 1'b0, 1'b0, 32'h0, 16'h0);
    if (sram) m_sv = 1'b0;
    for (int i = 0; i <= w1; i++)
      junk(1'($urandom), (i == w1) ? lo : 16'($urandom),
           1'b1, !w, w, a1, d1);
    if (!sram) begin
      m_sa = a[24:1] + 24'd1;
      m_sv = 1'b1;
    end
    if (two) begin
      for (int i = 0; i <= ss; i++) begin
        junk(1'($urandom), (i == ss) ? hi : 16'($urandom),
             1'b1, !w, w, a2, d2);
        if (abort && i == 0) begin
          #2;
          chk_en = 1'b0;
          req = 1'b0;
          rst_b = 1'b0;
          #1;
          chk("rst_cart_rd", {31'b0, cart_rd}, 32'd0);
          chk("rst_pause", {31'b0, pause}, 32'd0);
          chk("rst_rdata", rdata, 32'h0);
          chk("rst_cart_addr", cart_addr, 32'h0);
          m_sv = 1'b0;
          m_rdata = 32'h0;
          return;
        end
      end
      m_sa = a[24:1] + 24'd2;
    end
    if (!w) begin
      if (two)             m_rdata = {hi, lo};
      else if (sram)       m_rdata = {4{lo[7:0]}};
      else if (sz == 2'd0) m_rdata = {4{a[0] ? lo[15:8] : lo[7:0]}};
      else                 m_rdata = {lo, lo};
    end
    junk(rq_done, 16'($urandom), 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    for (int g = 0; g < gap; g++) begin
      junk(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
      m_sv = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, nxt;
    logic [1:0]  sz;
    logic        w, have;
    int          gap;
    #1;
    chk("reset_pause", {31'b0, pause}, 32'd0);
    chk("reset_strobe", {30'b0, cart_rd, cart_wr}, 32'd0);
    chk("reset_addr", cart_addr, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    access(0, 32'h0800_0000, 2'd1, 32'h0, 16'h0000, 16'h1234, 16'h0, 1, 0, 0);
    chk("t1_pause_cycles", n_pause, 6);
    chk("t1_rd_cycles", n_strobe, 5);
    chk("t1_rdata", rdata, 32'h1234_1234);

    access(0, 32'h0800_0100, 2'd2, 32'h0, 16'h0014, 16'hBBBB, 16'hAAAA, 0, 1, 0);
    chk("t2_pause_cycles", n_pause, 7);
    chk("t2_rd_cycles", n_strobe, 6);
    chk("t2_rdata", rdata, 32'hAAAA_BBBB);

    access(0, 32'h0800_0104, 2'd1, 32'h0, 16'h0014, 16'h5A5A, 16'h0, 1, 0, 0);
    chk("t3_seq_rd_cycles", n_strobe, 2);
    chk("t3_seq_pause_cycles", n_pause, 3);

    access(0, 32'h0800_0106, 2'd1, 32'h0, 16'h0014, 16'h0106, 16'h0, 0, 0, 0);
    chk("t4_gap_rd_cycles", n_strobe, 4);

    access(0, 32'h0801_FFFE, 2'd1, 32'h0, 16'h0014, 16'hFFFE, 16'h0, 0, 0, 0);
    access(0, 32'h0802_0000, 2'd1, 32'h0, 16'h0014, 16'h2000, 16'h0, 0, 0, 0);
    chk("t6_boundary_rd_cycles", n_strobe, 4);

    access(1, 32'h0E00_0005, 2'd0, 32'h0000_00A5, 16'h0003, 16'h0, 16'h0, 0, 0, 0);
    chk("t7_sram_wr_cycles", n_strobe, 9);
    chk("t7_sram_pause_cycles", n_pause, 10);

    access(0, 32'h0800_0100, 2'd2, 32'h0, 16'h0014, 16'h1111, 16'h2222, 0, 0, 1);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    access(0, 32'h0800_0102, 2'd1, 32'h0, 16'h0014, 16'h3333, 16'h0, 0, 0, 0);
    chk("t9_after_reset_rd_cycles", n_strobe, 4);

    have = 1'b0;
    nxt = '0;
    for (int k = 0; k < 400; k++) begin
      sz = 2'($urandom_range(0, 2));
      w = 1'($urandom);
      if (have && $urandom_range(0, 2) != 0) begin
        a = nxt;
      end else begin
        a = {4'h0, 1'b1, 2'($urandom), 25'($urandom)};
        if ($urandom_range(0, 7) == 0) a[16:0] = 17'h1FFFE;
      end
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      access(w, a, sz, $urandom, 16'($urandom), 16'($urandom),
             16'($urandom), gap, 1'($urandom), 0);
      have = (a[26:25] != 2'd3);
      nxt = {a[31:1], 1'b0} + ((sz == 2'd2) ? 32'd4 : 32'd2);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
